// File: rtl/wide_add_seq_pkg.sv
// Shared types and helpers for the wide_add_seq sequencer.
package wide_add_pkg;

  localparam int unsigned SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice index width: ceil(log2(width/SLICE_W)), never below 1.
  function automatic int unsigned idx_width(input int unsigned width);
    int unsigned n;
    int unsigned w;
    n = width / SLICE_W;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Requester-side bus of wide_add_seq; the sub signal exists only with WIDE_ADD_SUB_EN.
interface wide_add_seq_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef WIDE_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
`ifdef WIDE_ADD_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/add16_slice.sv
// Combinational 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module add16_slice (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    // Second-level lookahead across the four groups, expanded from cin.
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);
    for (int unsigned k = 0; k < 4; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
    sum  = p ^ c;
    cout = gc[4];
  end

endmodule

// File: rtl/wide_add_seq.sv
// WIDTH-bit adder sequencing one shared 16-bit CLA slice per cycle, LSB slice first.
// Optional subtract support via WIDE_ADD_SUB_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  wide_add_seq_if.slave bus
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDXW   = idx_width(WIDTH);
  localparam logic [IDXW-1:0] LAST = IDXW'(NSLICE - 1);

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   sum_r;
  logic               carry_r;
  logic               cout_r;
  logic               ovf_r;
  logic [IDXW-1:0]    idx;

  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;

`ifdef WIDE_ADD_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as "no borrow".
  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub | bus.cin;
`else
  assign b_eff = bus.b;
  assign c_eff = bus.cin;
`endif

  assign sl_a = a_r[idx*SLICE_W +: SLICE_W];
  assign sl_b = b_r[idx*SLICE_W +: SLICE_W];

  add16_slice u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_r),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= b_eff;
            carry_r <= c_eff;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum_r[idx*SLICE_W +: SLICE_W] <= sl_sum;
          carry_r <= sl_cout;
          if (idx == LAST) begin
            cout_r <= sl_cout;
            ovf_r  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_sum[SLICE_W-1] != a_r[WIDTH-1]);
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_wide_add_seq.sv
// Randomized self-checking bench for wide_add_seq against an arithmetic reference model.
module tb_wide_add_seq;

  localparam int unsigned W      = 64;
  localparam int unsigned NSLICE = W / 16;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  wide_add_seq_if #(.WIDTH(W)) bus ();

  wide_add_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference model: whole-word arithmetic, result published NSLICE+1 cycles after accept.
  bit             m_valid = 1'b0;
  bit             m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0]   m_sum;
  int             m_rem;
  logic [W-1:0]   p_sum;
  bit             p_cout, p_ovf;
  logic [W-1:0]   r_be;
  logic           r_ci;
  logic [W:0]     r_full;
  logic           r_sub;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_done = 0; m_sum = '0; m_cout = 0; m_ovf = 0; m_rem = 0;
      m_valid = 1;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else begin
      m_done = 0;
      if (bus.start) begin
`ifdef WIDE_ADD_SUB_EN
        r_sub = bus.sub;
`else
        r_sub = 1'b0;
`endif
        r_be   = r_sub ? ~bus.b : bus.b;
        r_ci   = r_sub ? 1'b1 : bus.cin;
        r_full = {1'b0, bus.a} + {1'b0, r_be} + {{W{1'b0}}, r_ci};
        p_sum  = r_full[W-1:0];
        p_cout = r_full[W];
        p_ovf  = (bus.a[W-1] == r_be[W-1]) && (r_full[W-1] != bus.a[W-1]);
        m_busy = 1;
        m_rem  = NSLICE;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_busy", bus.busy, m_busy);
      chk("m_done", bus.done, m_done);
      chk("m_cout", bus.cout, m_cout);
      chk("m_ovf",  bus.ovf,  m_ovf);
      if (!m_busy) chk("m_sum", bus.sum, m_sum);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (!bus.done && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic ts);
    bus.a   = ta;
    bus.b   = tb_v;
    bus.cin = tc;
`ifdef WIDE_ADD_SUB_EN
    bus.sub = ts;
`else
    r_sub   = ts & 1'b0;
`endif
  endtask

  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts, input logic [W-1:0] es,
                       input logic ec, input logic eo);
    int cyc;
    drive(ta, tb_v, tc, ts);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk({nm, "_busy1"}, bus.busy, 1);
    wait_done(1, cyc);
    chk({nm, "_lat"},  cyc, NSLICE + 1);
    chk({nm, "_sum"},  bus.sum, es);
    chk({nm, "_cout"}, bus.cout, ec);
    chk({nm, "_ovf"},  bus.ovf, eo);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [W-1:0] ra, rb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_sum",  bus.sum,  0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf",  bus.ovf,  0);
    rst_n = 1'b1;
    tick();

    do_op("carry_all", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    do_op("cin_part",  64'h0000_FFFF_0000_FFFF, 64'd1, 1'b1, 1'b0, 64'h0000_FFFF_0001_0001, 1'b0, 1'b0);
    do_op("ovf",       64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    tick();

    // start during RUN must be ignored
    drive(64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    drive(64'hDEAD_BEEF_0000_0001, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(3, cyc);
    chk("ign_lat", cyc, NSLICE + 1);
    chk("ign_sum", bus.sum, 64'h1212_2323_3434_4545);
    do_op("b2b", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    do_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    do_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0);
`endif

    // Abort: previous op leaves sum=1, cout=1 so the reset clear is visible
    do_op("pre_abort", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 64'd1, 1'b1, 1'b0);
    tick();
    drive(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_sum",  bus.sum,  0);
    chk("abort_cout", bus.cout, 0);
    seen = 0;
    repeat (8) begin
      tick();
      if (bus.done) seen++;
    end
    chk("abort_no_done", seen, 0);

    for (int i = 0; i < 60; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        drive({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(2, cyc);
      end else begin
        wait_done(1, cyc);
      end
      chk("rnd_lat", cyc, NSLICE + 1);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
